// File: rtl/fc_mac_arbiter.sv
// fc_mac_arbiter: job-level round-robin arbiter sharing one pipelined MAC
// among NREQ dot-product requesters.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/ready/last [NREQ] per-requester operand handshake and job end
//   req_a, req_b [NREQ*WIDTH]   packed operands, requester i at [i*WIDTH +: WIDTH]
//   mac_clear                   MAC accumulator/pipeline reset
//   mac_valid_in, mac_a, mac_b  operand strobe and operands to the MAC
//   mac_f                       MAC accumulator output
//   res_valid/res_ready         result handshake
//   res_data, res_id, res_ops   job result, owning requester, op count
module fc_mac_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NREQ    = 2,
   parameter int unsigned MAC_LAT = 3,
   parameter int unsigned MAX_OPS = 64,
   parameter bit          RELU    = 1'b0,
   localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int unsigned OPW    = $clog2(MAX_OPS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]         req_last,
   output logic                    mac_clear,
   output logic                    mac_valid_in,
   output logic [WIDTH-1:0]        mac_a,
   output logic [WIDTH-1:0]        mac_b,
   input  logic [WIDTH-1:0]        mac_f,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WIDTH-1:0]        res_data,
   output logic [IDW-1:0]          res_id,
   output logic [OPW-1:0]          res_ops
);

   localparam int unsigned DCW = $clog2(MAC_LAT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      RESULT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [OPW-1:0]   ops_q, ops_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [IDW-1:0]   res_id_q, res_id_d;
   logic [OPW-1:0]   res_ops_q, res_ops_d;

   logic             any_req;
   logic [IDW-1:0]   pick;
   logic [IDW-1:0]   cand;
   logic [OPW-1:0]   ops_inc;

   // Round-robin search: first valid requester at or above rr_q, with wrap.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(rr_q) + k) % NREQ);
         if (!any_req && req_valid[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   assign ops_inc = ops_q + OPW'(1);

   // Next-state and combinational MAC-side outputs.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      grant_d      = grant_q;
      ops_d        = ops_q;
      drain_d      = drain_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      res_ops_d    = res_ops_q;
      req_ready    = '0;
      mac_clear    = reset;
      mac_valid_in = 1'b0;
      mac_a        = '0;
      mac_b        = '0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            mac_clear = 1'b1;
            ops_d     = '0;
            state_d   = STREAM;
         end
         STREAM: begin
            req_ready[grant_q] = 1'b1;
            mac_a              = req_a[32'(grant_q)*WIDTH +: WIDTH];
            mac_b              = req_b[32'(grant_q)*WIDTH +: WIDTH];
            mac_valid_in       = req_valid[grant_q];
            if (req_valid[grant_q]) begin
               ops_d = ops_inc;
               // Reaching MAX_OPS ends the job even without req_last.
               if (req_last[grant_q] || (ops_inc == OPW'(MAX_OPS))) begin
                  drain_d = DCW'(MAC_LAT);
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            drain_d = drain_q - DCW'(1);
            // mac_f holds the final sum in the last drain cycle.
            if (drain_q == DCW'(1)) begin
               res_data_d = (RELU && mac_f[WIDTH-1]) ? '0 : mac_f;
               res_id_d   = grant_q;
               res_ops_d  = ops_q;
               state_d    = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               rr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         grant_q    <= '0;
         ops_q      <= '0;
         drain_q    <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
         res_ops_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         ops_q      <= ops_d;
         drain_q    <= drain_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_ops_q  <= res_ops_d;
      end
   end

   assign res_valid = (state_q == RESULT);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_ops   = res_ops_q;

endmodule

// File: tb/tb_fc_mac_arbiter.sv
// tb_fc_mac_arbiter: bench for fc_mac_arbiter with a behavioural 3-stage
// saturating MAC per DUT (one with RELU=0, one with RELU=1, same stimulus).
module tb_fc_mac_arbiter;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic               last;
   } op_t;

   typedef struct packed {
      logic [15:0] d;
      logic [15:0] r;
      logic [6:0]  ops;
   } exp_t;

   typedef struct packed {
      logic             id;
      logic [2:0]       n;
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      logic [15:0]      exp_d;
      logic [15:0]      exp_r;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req_valid;
   logic [2*W-1:0]    req_a, req_b;
   logic [1:0]        req_last;
   logic              res_ready;

   logic [1:0]        req_ready, req_ready_r;
   logic              mclr [2];
   logic              mv [2];
   logic signed [15:0] ma [2];
   logic signed [15:0] mb [2];
   logic signed [15:0] mf [2];
   logic              res_valid, res_valid_r;
   logic [15:0]       res_data, res_data_r;
   logic              res_id, res_id_r;
   logic [6:0]        res_ops, res_ops_r;

   always #5 clk = ~clk;

   fc_mac_arbiter #(.WIDTH(16), .NREQ(2), .MAC_LAT(3), .MAX_OPS(64), .RELU(1'b0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_last(req_last),
      .mac_clear(mclr[0]), .mac_valid_in(mv[0]), .mac_a(ma[0]), .mac_b(mb[0]), .mac_f(mf[0]),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .res_ops(res_ops));

   fc_mac_arbiter #(.WIDTH(16), .NREQ(2), .MAC_LAT(3), .MAX_OPS(64), .RELU(1'b1)) dut_relu (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_r),
      .req_a(req_a), .req_b(req_b), .req_last(req_last),
      .mac_clear(mclr[1]), .mac_valid_in(mv[1]), .mac_a(ma[1]), .mac_b(mb[1]), .mac_f(mf[1]),
      .res_valid(res_valid_r), .res_ready(res_ready), .res_data(res_data_r),
      .res_id(res_id_r), .res_ops(res_ops_r));

   // Behavioural MAC: product stage, delay stage, saturating accumulator.
   function automatic logic signed [15:0] sat(input longint x);
      if (x > 32767)  return 16'sh7fff;
      if (x < -32768) return 16'sh8000;
      return 16'(x);
   endfunction

   logic signed [15:0] p1 [2];
   logic signed [15:0] p2 [2];
   logic signed [15:0] acc [2];
   logic               v1 [2];
   logic               v2 [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mclr[k]) begin
            p1[k] <= '0; p2[k] <= '0; acc[k] <= '0; v1[k] <= 1'b0; v2[k] <= 1'b0;
         end else begin
            v1[k] <= mv[k];
            p1[k] <= sat(longint'(ma[k]) * longint'(mb[k]));
            v2[k] <= v1[k];
            p2[k] <= p1[k];
            if (v2[k]) acc[k] <= sat(longint'(acc[k]) + longint'(p2[k]));
         end
      end
   end

   always_comb begin
      mf[0] = acc[0];
      mf[1] = acc[1];
   end

   int   tests = 0;
   int   fails = 0;
   int   results = 0;
   int   expected_results = 0;
   int   cyc = 0;
   int   last_mv = 0;
   int   bad_onehot = 0;
   int   bad_pair = 0;
   logic prev_rv = 1'b0;
   logic [1:0] xfer = 2'b00;
   op_t  opq [2][$];
   exp_t sb  [2][$];
   int   ids_seen [$];
   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: invariants, latency, and scoreboard pop on result handshake.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if ((req_ready & (req_ready - 2'b01)) != 2'b00) bad_onehot++;
         if (req_ready !== req_ready_r || res_valid !== res_valid_r) bad_pair++;
         if (mv[0]) last_mv = cyc;
         if (res_valid && !prev_rv) check("result_latency", 32'(cyc - last_mv), 32'd4);
         if (res_valid && res_ready) begin
            if (sb[res_id].size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_result: id %0d data 0x%0h with none expected", res_id, res_data);
            end else begin
               exp_t e;
               e = sb[res_id].pop_front();
               check("res_data", 32'(res_data), 32'(e.d));
               check("res_data_relu", 32'(res_data_r), 32'(e.r));
               check("res_ops", 32'(res_ops), 32'(e.ops));
               check("res_id_relu", 32'(res_id_r), 32'(res_id));
            end
            ids_seen.push_back(int'(res_id));
            results++;
         end
         prev_rv = res_valid;
         xfer = req_valid & req_ready & {2{~reset}};
      end
   end

   // Requester drivers: present the head op of each queue, advance on transfer.
   initial begin
      req_valid = '0; req_a = '0; req_b = '0; req_last = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int r = 0; r < 2; r++) begin
            if (reset) opq[r].delete();
            else if (xfer[r] && opq[r].size() > 0) void'(opq[r].pop_front());
            if (opq[r].size() > 0) begin
               req_valid[r]      = 1'b1;
               req_a[r*W +: W]   = opq[r][0].a;
               req_b[r*W +: W]   = opq[r][0].b;
               req_last[r]       = opq[r][0].last;
            end else begin
               req_valid[r] = 1'b0;
               req_last[r]  = 1'b0;
            end
         end
      end
   end

   task automatic job(input int r, input int n, input logic [3:0][15:0] a,
                      input logic [3:0][15:0] b, input logic [15:0] ed, input logic [15:0] er);
      exp_t e;
      for (int i = 0; i < n; i++) opq[r].push_back('{a: a[i], b: b[i], last: (i == n - 1)});
      e.d = ed; e.r = er; e.ops = 7'(n);
      sb[r].push_back(e);
      expected_results++;
   endtask

   task automatic wait_results(input string name);
      int budget = 0;
      while (results < expected_results && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (results < expected_results) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got %0d results expected %0d", name, results, expected_results);
         expected_results = results;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int rv_cnt;
      int mv_cnt;
      int budget;
      reset = 1'b1;
      res_ready = 1'b1;

      vecs[0] = '{id: 1'b0, n: 3'd2, a: {16'sd0, 16'sd0, 16'sd4, 16'sd3},
                  b: {16'sd0, 16'sd0, 16'sd6, 16'sd5}, exp_d: 16'sd39, exp_r: 16'sd39};
      vecs[1] = '{id: 1'b1, n: 3'd1, a: {16'sd0, 16'sd0, 16'sd0, 16'sd200},
                  b: {16'sd0, 16'sd0, 16'sd0, 16'sd200}, exp_d: 16'sd32767, exp_r: 16'sd32767};
      vecs[2] = '{id: 1'b0, n: 3'd2, a: {16'sd0, 16'sd0, -16'sd10, 16'sd5},
                  b: {16'sd0, 16'sd0, 16'sd4, 16'sd1}, exp_d: -16'sd35, exp_r: 16'sd0};
      vecs[3] = '{id: 1'b1, n: 3'd3, a: {16'sd0, 16'sd1, -16'sd200, -16'sd200},
                  b: {16'sd0, 16'sd5, 16'sd200, 16'sd200}, exp_d: -16'sd32763, exp_r: 16'sd0};
      vecs[4] = '{id: 1'b0, n: 3'd4, a: {16'sd4, 16'sd3, 16'sd2, 16'sd1},
                  b: {16'sd1, 16'sd1, 16'sd1, 16'sd1}, exp_d: 16'sd10, exp_r: 16'sd10};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_mac_clear", 32'(mclr[0]), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mac_valid", 32'(mv[0]), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_res_ops", 32'(res_ops), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Table-driven single jobs.
      for (int i = 0; i < 5; i++) begin
         job(int'(vecs[i].id), int'(vecs[i].n), vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_r);
         wait_results("vector");
      end

      // Backpressure: r0 result held, r1 job pending behind it.
      @(posedge clk); #1 res_ready = 1'b0;
      job(0, 2, {16'sd0, 16'sd0, 16'sd3, 16'sd2}, {16'sd0, 16'sd0, 16'sd5, 16'sd4}, 16'sd23, 16'sd23);
      repeat (3) @(negedge clk);
      job(1, 1, {16'sd0, 16'sd0, 16'sd0, 16'sd1}, {16'sd0, 16'sd0, 16'sd0, 16'sd1}, 16'sd1, 16'sd1);
      budget = 0;
      while (!res_valid && budget < 100) begin @(negedge clk); budget++; end
      check("bp_res_valid_seen", 32'(res_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res_data", 32'(res_data), 32'd23);
         check("bp_res_id", 32'(res_id), 32'd0);
         check("bp_no_grant", 32'({req_ready, mclr[0]}), 32'd0);
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_valid", 32'(res_valid), 32'd0);
      check("bp_idle_clear", 32'(mclr[0]), 32'd0);
      @(negedge clk);
      check("bp_then_clear", 32'(mclr[0]), 32'd1);
      wait_results("backpressure");

      // Reset after two of four ops of a r0 job.
      job(0, 4, {16'sd1, 16'sd1, 16'sd1, 16'sd1}, {16'sd1, 16'sd1, 16'sd1, 16'sd1}, 16'sd4, 16'sd4);
      mv_cnt = 0; budget = 0;
      while (mv_cnt < 2 && budget < 100) begin
         @(negedge clk);
         if (mv[0]) mv_cnt++;
         budget++;
      end
      check("abort_ops_seen", 32'(mv_cnt), 32'd2);
      @(posedge clk); #1 reset = 1'b1;
      sb[0].delete(); sb[1].delete();
      expected_results = results;
      @(negedge clk);
      @(negedge clk);
      check("abort_mac_clear", 32'(mclr[0]), 32'd1);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_mac_valid", 32'(mv[0]), 32'd0);
      check("abort_res_valid", 32'(res_valid), 32'd0);
      check("abort_res_fields", 32'({res_data, res_id, res_ops}), 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      rv_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid) rv_cnt++;
      end
      check("abort_no_result", 32'(rv_cnt), 32'd0);
      job(1, 1, {16'sd0, 16'sd0, 16'sd0, 16'sd7}, {16'sd0, 16'sd0, 16'sd0, -16'sd3}, -16'sd21, 16'sd0);
      wait_results("post_reset");

      // Fairness: both requesters continuously valid with 3-op jobs.
      ids_seen.delete();
      job(0, 3, {16'sd0, 16'sd3, 16'sd2, 16'sd1}, {16'sd0, 16'sd2, 16'sd2, 16'sd2}, 16'sd12, 16'sd12);
      job(1, 3, {16'sd0, -16'sd3, -16'sd2, -16'sd1}, {16'sd0, 16'sd1, 16'sd1, 16'sd1}, -16'sd6, 16'sd0);
      job(0, 3, {16'sd0, 16'sd1, 16'sd1, 16'sd1}, {16'sd0, 16'sd7, 16'sd7, 16'sd7}, 16'sd21, 16'sd21);
      job(1, 3, {16'sd0, 16'sd10, 16'sd10, 16'sd10}, {16'sd0, 16'sd10, 16'sd10, 16'sd10}, 16'sd300, 16'sd300);
      wait_results("fairness");
      check("fair_count", 32'(ids_seen.size()), 32'd4);
      for (int i = 0; i < 4 && i < ids_seen.size(); i++)
         check("fair_order", 32'(ids_seen[i]), 32'(i % 2));

      // Op-count overflow: 64 ops with no req_last end the job.
      begin
         exp_t e;
         for (int i = 0; i < 64; i++) opq[1].push_back('{a: 16'sd1, b: 16'sd1, last: 1'b0});
         e.d = 16'd64; e.r = 16'd64; e.ops = 7'd64;
         sb[1].push_back(e);
         expected_results++;
      end
      wait_results("overflow");
      job(0, 1, {16'sd0, 16'sd0, 16'sd0, -16'sd1}, {16'sd0, 16'sd0, 16'sd0, 16'sd1}, -16'sd1, 16'sd0);
      wait_results("after_overflow");

      check("req_ready_onehot", 32'(bad_onehot), 32'd0);
      check("relu_dut_lockstep", 32'(bad_pair), 32'd0);
      check("scoreboard_empty", 32'(sb[0].size() + sb[1].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
